// File: rtl/sdvm_digit_sequencer_if.sv
// Digit handshake between the upstream digit-recurrence unit (master)
// and the SDVM digit sequencer (slave).
interface sdvm_digit_sequencer_if;
    logic [1:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;

    modport master (output digit_in, output digit_valid, input digit_ready);
    modport slave  (input digit_in, input digit_valid, output digit_ready);
endinterface

// File: rtl/sdvm_digit_sequencer.sv
// Sequences one signed-digit vector multiplier stage: buffers quotient digits,
// inserts online-delay warm-up cycles, then issues one digit select per cycle.
module sdvm_digit_sequencer #(
    parameter int ITER       = 64,
    parameter int DELAY      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 7
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic                 start,
    sdvm_digit_sequencer_if.slave dig,
    output logic [1:0]           sel_out,
    output logic                 sdvm_enable,
    output logic [CW-1:0]        iter_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err_illegal
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [WW-1:0] WLAST  = (DELAY > 0) ? WW'(DELAY - 1) : '0;
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] ITER_C = CW'(ITER);
    localparam logic [CW-1:0] LAST_C = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] pushed_q, pushed_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [1:0]    sel_q, sel_d;
    logic          en_q, en_d;
    logic          err_q, err_d;

    logic [1:0]    mem [FIFO_DEPTH];
    logic          dig_ready;
    logic          push, pop;
    logic [1:0]    pop_dig;

    assign push    = dig.digit_valid && dig_ready;
    assign pop     = (state_q == S_RUN) && (cnt_q != '0);
    assign pop_dig = mem[rd_q];

    // State register
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            pushed_q <= '0;
            iter_q   <= '0;
            sel_q    <= 2'b00;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            pushed_q <= pushed_d;
            iter_q   <= iter_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            err_q    <= err_d;
        end
    end

    // Digit storage carries no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= dig.digit_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        iter_d   = iter_q;
        err_d    = err_q;
        pushed_d = pushed_q;
        sel_d    = 2'b00;
        en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = (DELAY > 0) ? S_WARMUP : S_RUN;
                    wcnt_d   = '0;
                    iter_d   = '0;
                    err_d    = 1'b0;
                    pushed_d = '0;
                end
            end
            S_WARMUP: begin
                en_d = 1'b1;
                if (wcnt_q == WLAST) begin
                    state_d = S_RUN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (pop) begin
                    en_d   = 1'b1;
                    iter_d = iter_q + 1'b1;
                    // An illegal 11 still advances the multiplier, but as a zero digit.
                    if (pop_dig == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d = pop_dig;
                    end
                    if (iter_q == LAST_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            pushed_d = pushed_q + 1'b1;
        end

        rd_d = pop  ? rd_q + 1'b1 : rd_q;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output decode; ready ignores this cycle's pop and stops after ITER pushes.
    always_comb begin
        busy      = (state_q == S_WARMUP) || (state_q == S_RUN);
        done      = (state_q == S_DONE);
        dig_ready = busy && (cnt_q != FULL) && (pushed_q < ITER_C);
    end

    assign dig.digit_ready = dig_ready;
    assign sel_out         = sel_q;
    assign sdvm_enable     = en_q;
    assign iter_count      = iter_q;
    assign err_illegal     = err_q;

endmodule

// File: tb/tb_sdvm_digit_sequencer.sv
// Bench for sdvm_digit_sequencer: a queue-based reference model checked every
// cycle against an ITER=8/DELAY=4 instance, plus directed ITER=1/DELAY=0 checks.
module tb_sdvm_digit_sequencer;

    localparam int A_ITER = 8;
    localparam int A_DELAY = 4;
    localparam int A_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    int nchk = 0;
    int nerr = 0;

    sdvm_digit_sequencer_if a_if ();
    sdvm_digit_sequencer_if b_if ();

    logic [1:0] a_sel, b_sel;
    logic       a_en, b_en, a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [3:0] a_iter;
    logic [1:0] b_iter;

    sdvm_digit_sequencer #(.ITER(A_ITER), .DELAY(A_DELAY), .FIFO_DEPTH(A_DEPTH), .CW(4)) dut_a (
        .clk(clk), .asyn_reset(rst_n), .start(start_a), .dig(a_if.slave),
        .sel_out(a_sel), .sdvm_enable(a_en), .iter_count(a_iter),
        .busy(a_busy), .done(a_done), .err_illegal(a_err));

    sdvm_digit_sequencer #(.ITER(1), .DELAY(0), .FIFO_DEPTH(2), .CW(2)) dut_b (
        .clk(clk), .asyn_reset(rst_n), .start(start_b), .dig(b_if.slave),
        .sel_out(b_sel), .sdvm_enable(b_en), .iter_count(b_iter),
        .busy(b_busy), .done(b_done), .err_illegal(b_err));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Producer for instance A: offers src[0] whenever the queue is non-empty.
    logic [1:0] src[$];
    logic       fired;
    initial begin
        a_if.digit_valid = 1'b0;
        a_if.digit_in    = 2'b00;
        b_if.digit_valid = 1'b1;
        b_if.digit_in    = 2'b01;
    end
    always begin
        @(posedge clk);
        fired = a_if.digit_valid && a_if.digit_ready;
        @(negedge clk);
        if (fired && src.size() > 0) void'(src.pop_front());
        a_if.digit_valid = (src.size() > 0);
        a_if.digit_in    = (src.size() > 0) ? src[0] : 2'b00;
    end

    // Reference model: phase 0 idle, 1 warm-up, 2 issuing, 3 done.
    int         m_ph = 0, m_wc = 0, m_pushed = 0, m_iss = 0;
    int         m_sel = 0, m_en = 0, m_err = 0;
    logic [1:0] m_q[$];
    always @(posedge clk) begin
        bit         rdy, psh, popd;
        logic [1:0] d;
        logic [1:0] pdig;
        if (!rst_n) begin
            m_ph = 0; m_wc = 0; m_pushed = 0; m_iss = 0;
            m_sel = 0; m_en = 0; m_err = 0;
            m_q.delete();
        end else begin
            rdy  = (m_ph == 1 || m_ph == 2) && m_q.size() < A_DEPTH && m_pushed < A_ITER;
            psh  = a_if.digit_valid && rdy;
            pdig = a_if.digit_in;
            popd = (m_ph == 2) && m_q.size() > 0;
            m_sel = 0;
            m_en  = 0;
            case (m_ph)
                0: if (start_a) begin
                    m_iss = 0; m_err = 0; m_wc = 0; m_pushed = 0;
                    m_ph = (A_DELAY > 0) ? 1 : 2;
                end
                1: begin
                    m_en = 1;
                    m_wc++;
                    if (m_wc == A_DELAY) m_ph = 2;
                end
                2: if (popd) begin
                    d = m_q.pop_front();
                    m_en = 1;
                    if (d == 2'b11) m_err = 1;
                    else m_sel = d;
                    m_iss++;
                    if (m_iss == A_ITER) m_ph = 3;
                end
                default: m_ph = 0;
            endcase
            if (psh) begin
                m_q.push_back(pdig);
                m_pushed++;
            end
        end
    end

    // Per-cycle comparison of instance A against the model.
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        chk("A.sel", a_sel, m_sel);
        chk("A.en", a_en, m_en);
        chk("A.iter", a_iter, m_iss);
        chk("A.err", a_err, m_err);
        chk("A.busy", a_busy, int'(m_ph == 1 || m_ph == 2));
        chk("A.done", a_done, int'(m_ph == 3));
        chk("A.ready", a_if.digit_ready,
            int'((m_ph == 1 || m_ph == 2) && m_q.size() < A_DEPTH && m_pushed < A_ITER));
        if (a_done) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
    endtask

    task automatic wait_iter(input int n);
        int k;
        for (k = 0; k < 200 && a_iter != n; k++) cyc();
        chk("A.wait_iter_timeout", int'(a_iter == n), 1);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200 && !a_done; k++) cyc();
        chk("A.wait_done_timeout", a_done, 1);
    endtask

    task automatic load8(input logic [1:0] d0, d1, d2, d3, d4, d5, d6, d7);
        src.push_back(d0); src.push_back(d1); src.push_back(d2); src.push_back(d3);
        src.push_back(d4); src.push_back(d5); src.push_back(d6); src.push_back(d7);
    endtask

    int exp_sel[14] = '{0, 0, 0, 0, 0, 2, 1, 0, 2, 1, 0, 2, 1, 0};
    int exp_en[14]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        int dc;
        #12;
        // Reset state
        chk("rst.sel", a_sel, 0);
        chk("rst.en", a_en, 0);
        chk("rst.iter", a_iter, 0);
        chk("rst.busy", a_busy, 0);
        chk("rst.ready", a_if.digit_ready, 0);
        chk("rst.b_ready", b_if.digit_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Streaming with prefetch during warm-up
        load8(2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01);
        pulse_start_a();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) cyc();
            chk("stream.sel", a_sel, exp_sel[k]);
            chk("stream.en", a_en, exp_en[k]);
            chk("stream.done", a_done, int'(k == 12));
            if (k == 4) chk("stream.full_ready", a_if.digit_ready, 0);
            if (k == 12) chk("stream.iter", a_iter, 8);
        end
        cyc();

        // Reset in the middle of RUN
        load8(2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10);
        pulse_start_a();
        wait_iter(3);
        dc = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.sel", a_sel, 0);
        chk("midrst.en", a_en, 0);
        chk("midrst.iter", a_iter, 0);
        chk("midrst.busy", a_busy, 0);
        chk("midrst.ready", a_if.digit_ready, 0);
        src.delete();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("midrst.no_done", done_cnt, dc);
        load8(2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10);
        pulse_start_a();
        wait_done();
        chk("midrst.restart_iter", a_iter, 8);
        cyc();

        // Producer stall after digit 2
        src.push_back(2'b10);
        src.push_back(2'b01);
        pulse_start_a();
        wait_iter(2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall.en", a_en, 0);
            chk("stall.sel", a_sel, 0);
            chk("stall.iter", a_iter, 2);
        end
        src.push_back(2'b00); src.push_back(2'b10); src.push_back(2'b01);
        src.push_back(2'b00); src.push_back(2'b10); src.push_back(2'b01);
        wait_done();
        chk("stall.iter_done", a_iter, 8);
        chk("stall.last_sel", a_sel, 1);
        cyc();

        // Illegal digit in position 3
        load8(2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
        pulse_start_a();
        wait_iter(3);
        chk("illegal.sel", a_sel, 0);
        chk("illegal.en", a_en, 1);
        chk("illegal.err", a_err, 1);
        wait_done();
        chk("illegal.err_at_done", a_err, 1);
        cyc();
        chk("illegal.err_idle", a_err, 1);
        load8(2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01);
        pulse_start_a();
        chk("illegal.err_cleared", a_err, 0);
        wait_done();
        cyc();

        // DELAY=0, ITER=1 with a digit already valid; start held while busy
        @(negedge clk);
        start_b = 1'b1;
        cyc();
        chk("b.busy0", b_busy, 1);
        chk("b.en0", b_en, 0);
        chk("b.ready0", b_if.digit_ready, 1);
        cyc();
        start_b = 1'b0;
        chk("b.en1", b_en, 0);
        chk("b.ready1", b_if.digit_ready, 0);
        cyc();
        chk("b.sel2", b_sel, 1);
        chk("b.en2", b_en, 1);
        chk("b.done2", b_done, 1);
        chk("b.iter2", b_iter, 1);
        cyc();
        chk("b.en3", b_en, 0);
        chk("b.done3", b_done, 0);
        chk("b.busy3", b_busy, 0);
        cyc();
        chk("b.busy4", b_busy, 0);
        chk("b.err", b_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

endmodule
